mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 3, SHALL set the number of cycles each memory access is held on the memory port (legal range 1..15).
REQ-002 Parameter ADDR_W, default 16, SHALL set the memory-port word-address width.
REQ-003 Parameter BASE_ADDR, default 1024, SHALL set the byte address that maps to memory word 0.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst  in  1  reset, synchronous, active-low.
REQ-006 if_req  in  1  fetch read request; held high until if_ready.
REQ-007 if_addr  in  32  fetch byte address.
REQ-008 if_rdata  out  32  fetch read data, valid while if_ready=1.
REQ-009 if_ready  out  1  one-cycle fetch completion pulse.
REQ-010 mem_rd / mem_wr  in  1 each  data read/write request; held until mem_ready.
REQ-011 mem_addr / mem_wdata  in  32 each  data byte address / store data.
REQ-012 mem_rdata  out  32  data read result, valid while mem_ready=1.
REQ-013 mem_ready  out  1  one-cycle data completion pulse.
REQ-014 ram_addr  out  ADDR_W  word address to memory.
REQ-015 ram_wdata / ram_rdata  out / in  32 each  memory write / read data.
REQ-016 ram_we_n / ram_oe_n  out  1 each  active-low write / output enables.
REQ-017 if_stall / mem_stall  out  1 each  pipeline freeze requests.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS and DONE, with a registered owner bit (IF or MEM) and a registered op bit (read or write).
REQ-019 In IDLE with any request pending, the block SHALL latch owner, op, word address and write data, then move to ACCESS on the next edge.
REQ-020 Arbitration SHALL give MEM priority, except that IF wins when both are pending and the previous grant went to MEM (last_owner=MEM); last_owner SHALL reset to IF.
REQ-021 When mem_rd and mem_wr are both high, the access SHALL be treated as a write.
REQ-022 Word address SHALL be ((addr - BASE_ADDR) >> 2) truncated to ADDR_W bits, with wrap-around (no bounds error).
REQ-023 In ACCESS, ram_addr SHALL be held stable; writes SHALL drive ram_we_n=0 and ram_oe_n=1; reads SHALL drive ram_oe_n=0 and ram_we_n=1.
REQ-024 A 4-bit counter SHALL run in ACCESS; on its WAIT_CYCLES-th ACCESS cycle, read data SHALL be captured from ram_rdata and the FSM SHALL move to DONE.
REQ-025 In DONE, the owner's ready SHALL be high for exactly one cycle with read data valid (write result data = 0); the FSM SHALL then return to IDLE, so back-to-back requests cost one IDLE cycle.
REQ-026 Latency SHALL be WAIT_CYCLES+2 cycles from the first cycle a request is sampled in IDLE to ready (ready in cycle t+WAIT_CYCLES+1).
REQ-027 Deasserting a request mid-access SHALL NOT abort the access; the ready pulse SHALL still be issued.
REQ-028 A request arriving while the FSM is busy SHALL be held off, not dropped.
REQ-029 if_stall SHALL equal if_req & ~if_ready and mem_stall SHALL equal (mem_rd|mem_wr) & ~mem_ready (combinational).
REQ-030 Outside ACCESS, ram_we_n and ram_oe_n SHALL be 1 and ram_addr SHALL hold its last value.

Reset
REQ-031 On a clock edge with rst=0, the block SHALL set state=IDLE, counter=0, last_owner=IF, if_ready=mem_ready=0, if_rdata=mem_rdata=0, ram_addr=0, ram_wdata=0 and ram_we_n=ram_oe_n=1.
REQ-032 Reset asserted mid-ACCESS SHALL abort the access: ram_we_n returns to 1 on that edge and no ready pulse is issued.

Verification (WAIT_CYCLES=3, BASE_ADDR=1024)
REQ-033 Single IF read, if_addr=1032, ram_rdata=0xDEADBEEF -> ram_addr=2 and ram_oe_n=0 for 3 cycles, if_ready pulse in cycle t+4 with if_rdata=0xDEADBEEF.
REQ-034 mem_wr at mem_addr=1028 with wdata=0x12345678 -> ram_addr=1, ram_we_n=0 for 3 cycles, mem_ready pulse, mem_stall high until that pulse.
REQ-035 if_req and mem_rd both held from reset -> order MEM, IF, MEM, IF with one IDLE cycle between grants; neither requester is starved.
REQ-036 mem_rd and mem_wr both high -> write performed (ram_we_n=0, ram_oe_n=1).
REQ-037 rst=0 in the 2nd ACCESS cycle of a write -> ram_we_n=1 on that edge, no ready pulse, FSM in IDLE; the request is re-served after rst=1.
REQ-038 if_req dropped in the 1st ACCESS cycle -> access completes and the if_ready pulse is still seen.

Source files
------------

// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Shares one wait-stated memory port between fetch and data.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int          WAIT_CYCLES = 3,
  parameter int          ADDR_W      = 16,
  parameter logic [31:0] BASE_ADDR   = 32'd1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ram_we_n,
  output logic              ram_oe_n,
  output logic              if_stall,
  output logic              mem_stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [3:0] c_LAST_CNT  = 4'(WAIT_CYCLES - 1);
  localparam logic       c_OWNER_IF  = 1'b0;
  localparam logic       c_OWNER_MEM = 1'b1;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_owner;
  logic        r_last_owner;
  logic        r_op_wr;

  logic        w_if_pend;
  logic        w_mem_pend;
  logic        w_grant_mem;
  logic        w_grant_wr;
  logic [31:0] w_sel_addr;
  logic [31:0] w_byte_off;

  assign w_if_pend  = if_req;
  assign w_mem_pend = mem_rd | mem_wr;
  // Data side normally wins; fetch gets the turn right after a data grant.
  assign w_grant_mem = w_mem_pend & ~(w_if_pend & (r_last_owner == c_OWNER_MEM));
  assign w_grant_wr  = w_grant_mem & mem_wr;
  assign w_sel_addr  = w_grant_mem ? mem_addr : if_addr;
  assign w_byte_off  = w_sel_addr - BASE_ADDR;

  assign if_stall  = if_req & ~if_ready;
  assign mem_stall = w_mem_pend & ~mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_owner      <= c_OWNER_IF;
      r_last_owner <= c_OWNER_IF;
      r_op_wr      <= 1'b0;
      if_ready     <= 1'b0;
      mem_ready    <= 1'b0;
      if_rdata     <= 32'd0;
      mem_rdata    <= 32'd0;
      ram_addr     <= '0;
      ram_wdata    <= 32'd0;
      ram_we_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_if_pend | w_mem_pend) begin
            r_owner      <= w_grant_mem;
            r_last_owner <= w_grant_mem;
            r_op_wr      <= w_grant_wr;
            ram_addr     <= ADDR_W'(w_byte_off >> 2);
            if (w_grant_wr) begin
              ram_wdata <= mem_wdata;
            end
            r_cnt    <= 4'd0;
            ram_we_n <= ~w_grant_wr;
            ram_oe_n <= w_grant_wr;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == c_LAST_CNT) begin
            ram_we_n <= 1'b1;
            ram_oe_n <= 1'b1;
            r_state  <= S_DONE;
            if (r_owner == c_OWNER_MEM) begin
              mem_ready <= 1'b1;
              mem_rdata <= r_op_wr ? 32'd0 : ram_rdata;
            end else begin
              if_ready <= 1'b1;
              if_rdata <= r_op_wr ? 32'd0 : ram_rdata;
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          if_ready  <= 1'b0;
          mem_ready <= 1'b0;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mem_arbiter: transaction-level model checked every cycle plus
// directed scenarios with literal expectations.
module tb_mem_arbiter;

  localparam int W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, mem_rd, mem_wr;
  logic [31:0] if_addr, mem_addr, mem_wdata;
  logic [31:0] if_rdata, mem_rdata, ram_wdata, ram_rdata;
  logic        if_ready, mem_ready, ram_we_n, ram_oe_n, if_stall, mem_stall;
  logic [15:0] ram_addr;

  logic [31:0] ram [64];
  assign ram_rdata = ram[ram_addr[5:0]];

  mem_arbiter #(.WAIT_CYCLES(W), .ADDR_W(16), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .ram_we_n(ram_we_n), .ram_oe_n(ram_oe_n),
    .if_stall(if_stall), .mem_stall(mem_stall)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: phase 0 = idle, 1..W = memory access, W+1 = completion cycle.
  int          m_phase = 0;
  bit          m_valid = 0;
  bit          m_owner_mem, m_wr, m_last_mem, m_ip, m_mp;
  logic [15:0] m_addr;
  logic [31:0] m_wdata, m_rdata, m_tmp;

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_phase = 0; m_last_mem = 0; m_addr = 16'd0; m_wr = 0; m_owner_mem = 0;
      m_valid = 1;
    end else if (m_valid) begin
      if (m_phase == 0) begin
        m_ip = if_req;
        m_mp = mem_rd | mem_wr;
        if (m_ip || m_mp) begin
          m_owner_mem = m_mp && !(m_ip && m_last_mem);
          m_last_mem  = m_owner_mem;
          m_wr        = m_owner_mem && mem_wr;
          m_tmp       = ((m_owner_mem ? mem_addr : if_addr) - 32'd1024) / 4;
          m_addr      = m_tmp[15:0];
          m_wdata     = mem_wdata;
          m_phase     = 1;
        end
      end else if (m_phase <= W) begin
        if (m_phase == W) m_rdata = m_wr ? 32'd0 : ram[m_addr[5:0]];
        m_phase++;
      end else begin
        m_phase = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      bit acc, done;
      acc  = (m_phase >= 1) && (m_phase <= W);
      done = (m_phase == W + 1);
      chk("ram_we_n", {31'd0, ram_we_n}, {31'd0, !(acc && m_wr)});
      chk("ram_oe_n", {31'd0, ram_oe_n}, {31'd0, !(acc && !m_wr)});
      chk("ram_addr", {16'd0, ram_addr}, {16'd0, m_addr});
      if (acc && m_wr) chk("ram_wdata", ram_wdata, m_wdata);
      chk("if_ready", {31'd0, if_ready}, {31'd0, done && !m_owner_mem});
      chk("mem_ready", {31'd0, mem_ready}, {31'd0, done && m_owner_mem});
      if (done && !m_owner_mem) chk("if_rdata", if_rdata, m_rdata);
      if (done && m_owner_mem) chk("mem_rdata", mem_rdata, m_rdata);
      chk("if_stall", {31'd0, if_stall}, {31'd0, if_req && !(done && !m_owner_mem)});
      chk("mem_stall", {31'd0, mem_stall},
          {31'd0, (mem_rd || mem_wr) && !(done && m_owner_mem)});
    end
  end

  task automatic run_txn(input bit use_if, input bit rd, input bit wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output int we_cnt, output int oe_cnt,
                         output logic [31:0] rdv, output logic [15:0] ra,
                         output bit stall0);
    @(posedge clk); #1;
    if (use_if) begin
      if_req = 1'b1; if_addr = addr;
    end else begin
      mem_rd = rd; mem_wr = wr; mem_addr = addr; mem_wdata = wdata;
    end
    lat = -1; we_cnt = 0; oe_cnt = 0; rdv = 32'd0; ra = 16'd0; stall0 = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) stall0 = use_if ? if_stall : mem_stall;
      if (!ram_we_n) we_cnt++;
      if (!ram_oe_n) oe_cnt++;
      if (use_if ? if_ready : mem_ready) begin
        lat = n;
        rdv = use_if ? if_rdata : mem_rdata;
        ra  = ram_addr;
        break;
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
  endtask

  int          lat, wec, oec;
  logic [31:0] rdv;
  logic [15:0] ra;
  bit          st0, got;
  int          order [$];
  int          stamp [$];

  initial begin
    for (int i = 0; i < 64; i++) ram[i] = 32'hA000_0000 + i;
    ram[2] = 32'hDEADBEEF;
    rst = 1'b0; if_req = 0; mem_rd = 0; mem_wr = 0;
    if_addr = 0; mem_addr = 0; mem_wdata = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("rst_we_n", {31'd0, ram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, ram_oe_n}, 32'd1);
    chk("rst_addr", {16'd0, ram_addr}, 32'd0);
    chk("rst_ready", {30'd0, if_ready, mem_ready}, 32'd0);
    chk("rst_rdata", if_rdata | mem_rdata, 32'd0);

    // Single fetch read
    run_txn(1, 0, 0, 32'd1032, 32'd0, lat, wec, oec, rdv, ra, st0);
    chk("if_lat", lat, W + 1);
    chk("if_oe_cycles", oec, W);
    chk("if_data", rdv, 32'hDEADBEEF);
    chk("if_raddr", {16'd0, ra}, 32'd2);

    // Data write
    run_txn(0, 0, 1, 32'd1028, 32'h12345678, lat, wec, oec, rdv, ra, st0);
    chk("wr_lat", lat, W + 1);
    chk("wr_we_cycles", wec, W);
    chk("wr_raddr", {16'd0, ra}, 32'd1);
    chk("wr_rdata_zero", rdv, 32'd0);
    chk("wr_stall", {31'd0, st0}, 32'd1);

    // Data read
    run_txn(0, 1, 0, 32'd1044, 32'd0, lat, wec, oec, rdv, ra, st0);
    chk("rd_lat", lat, W + 1);
    chk("rd_data", rdv, 32'hA000_0005);

    // Read and write together act as a write
    run_txn(0, 1, 1, 32'd1036, 32'hCAFEF00D, lat, wec, oec, rdv, ra, st0);
    chk("rw_we_cycles", wec, W);
    chk("rw_oe_cycles", oec, 0);

    // Address below base wraps around
    run_txn(0, 1, 0, 32'd1020, 32'd0, lat, wec, oec, rdv, ra, st0);
    chk("wrap_addr", {16'd0, ra}, 32'h0000FFFF);
    chk("wrap_data", rdv, 32'hA000_003F);

    // Both requesters held from reset alternate
    @(posedge clk); #1;
    rst = 1'b0; if_req = 1'b1; if_addr = 32'd1032; mem_rd = 1'b1; mem_addr = 32'd1024;
    @(posedge clk); #1 rst = 1'b1;
    for (int n = 0; n < 60 && order.size() < 4; n++) begin
      @(negedge clk);
      if (mem_ready) begin order.push_back(1); stamp.push_back(cyc); end
      if (if_ready)  begin order.push_back(0); stamp.push_back(cyc); end
    end
    @(posedge clk); #1 if_req = 1'b0; mem_rd = 1'b0;
    chk("order_count", order.size(), 4);
    if (order.size() == 4) begin
      chk("order_0_mem", order[0], 1);
      chk("order_1_if", order[1], 0);
      chk("order_2_mem", order[2], 1);
      chk("order_3_if", order[3], 0);
      for (int k = 1; k < 4; k++) chk("order_gap", stamp[k] - stamp[k-1], W + 2);
    end

    // Reset in the second access cycle of a write
    @(posedge clk); #1;
    mem_wr = 1'b1; mem_addr = 32'd1028; mem_wdata = 32'h55AA55AA;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ram_we_n) begin got = 1; break; end
    end
    chk("abort_started", {31'd0, got}, 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_we_n", {31'd0, ram_we_n}, 32'd1);
    chk("abort_no_ready", {31'd0, mem_ready}, 32'd0);
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (mem_ready) begin got = 1; break; end
    end
    chk("abort_reserved", {31'd0, got}, 32'd1);
    @(posedge clk); #1 mem_wr = 1'b0;

    // Fetch request dropped in the first access cycle still completes
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'd1040;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!ram_oe_n) begin got = 1; break; end
    end
    chk("drop_started", {31'd0, got}, 32'd1);
    @(posedge clk); #1 if_req = 1'b0;
    got = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (if_ready) begin got = 1; rdv = if_rdata; break; end
    end
    chk("drop_ready", {31'd0, got}, 32'd1);
    chk("drop_data", rdv, 32'hA000_0004);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
`default_nettype wire
